// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared fetch/execute definitions: instruction length, default reset and
// trap vectors, the PC-sequencer state encoding and the branch-op (funct3)
// encodings that the decoder and the compare unit both use.
// No ports.
// ---------------------------------------------------------------------------
package riscv_pkg;

   localparam int ILEN_BYTES = 4;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

   // PC sequencer states
   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_SHADOW = 2'd2,
      ST_TRAP   = 2'd3
   } state_e;

   // Branch-op encodings (funct3 of the B-type instructions)
   localparam logic [2:0] BR_EQ  = 3'b000;
   localparam logic [2:0] BR_NE  = 3'b001;
   localparam logic [2:0] BR_LT  = 3'b100;
   localparam logic [2:0] BR_GE  = 3'b101;
   localparam logic [2:0] BR_LTU = 3'b110;
   localparam logic [2:0] BR_GEU = 3'b111;

endpackage

// File: rtl/pc_redirect_if.sv
// ---------------------------------------------------------------------------
// pc_redirect_if
// Bundles the EX-stage redirect inputs, the fetch-side control inputs and
// the fetch/trap outputs of pc_redirect.
//   slave  : the PC sequencer (consumes redirects, drives pc_o etc.)
//   master : the surrounding pipeline (drives redirects, consumes pc_o etc.)
// ---------------------------------------------------------------------------
interface pc_redirect_if;

   logic        stall_i;
   logic        imem_ready;
   logic        br_valid;
   logic        Br_en;
   logic [31:0] br_target;
   logic        jmp_valid;
   logic [31:0] jmp_target;
   logic [31:0] pc_o;
   logic        pc_valid;
   logic        flush_o;
   logic        misalign_exc;
   logic [31:0] exc_pc;
   logic [31:0] br_taken_cnt;

   modport slave (
      input  stall_i, imem_ready, br_valid, Br_en, br_target,
             jmp_valid, jmp_target,
      output pc_o, pc_valid, flush_o, misalign_exc, exc_pc, br_taken_cnt
   );

   modport master (
      output stall_i, imem_ready, br_valid, Br_en, br_target,
             jmp_valid, jmp_target,
      input  pc_o, pc_valid, flush_o, misalign_exc, exc_pc, br_taken_cnt
   );

endinterface

// File: rtl/pc_shadow_cnt.sv
// ---------------------------------------------------------------------------
// pc_shadow_cnt
// Loadable 3-bit down-counter with a zero flag; times the redirect shadow.
// Ports:
//   clk, RSTn   : clock, synchronous active-low reset (count -> 0)
//   i_load      : load i_load_val (has priority over i_dec)
//   i_load_val  : value to load
//   i_dec       : decrement by one, saturating at zero
//   o_cnt       : current count
//   o_zero      : current count is zero
// ---------------------------------------------------------------------------
module pc_shadow_cnt (
   input  logic       clk,
   input  logic       RSTn,
   input  logic       i_load,
   input  logic [2:0] i_load_val,
   input  logic       i_dec,
   output logic [2:0] o_cnt,
   output logic       o_zero
);

   logic [2:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!RSTn) begin
         r_cnt <= 3'd0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != 3'd0)) begin
         r_cnt <= r_cnt - 3'd1;
      end
   end

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == 3'd0);

endmodule

// File: rtl/pc_redirect.sv
// ---------------------------------------------------------------------------
// pc_redirect
// Owns the fetch PC. Sequences PC+4 advance, taken-branch / jump redirects
// and misaligned-target traps. A redirect pulses flush_o combinationally and
// then opens a SHADOW-cycle window in which further redirects are ignored,
// so wrong-path branches still in ID/EX cannot redirect.
// Parameters:
//   RESET_PC : PC after reset
//   TRAP_VEC : PC after a misaligned-target trap
//   SHADOW   : redirect-ignore window in cycles, legal 1..7
// Ports:
//   clk       : rising-edge clock
//   RSTn      : synchronous active-low reset
//   bus.slave : stall_i, imem_ready, br_valid, Br_en, br_target, jmp_valid,
//               jmp_target in; pc_o, pc_valid, flush_o (combinational),
//               misalign_exc, exc_pc, br_taken_cnt out
// ---------------------------------------------------------------------------
module pc_redirect
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC,
   parameter int unsigned SHADOW   = 2
) (
   input  logic          clk,
   input  logic          RSTn,
   pc_redirect_if.slave  bus
);

   localparam logic [1:0] S_BOOT   = ST_BOOT;
   localparam logic [1:0] S_RUN    = ST_RUN;
   localparam logic [1:0] S_SHADOW = ST_SHADOW;
   localparam logic [1:0] S_TRAP   = ST_TRAP;

   localparam logic [2:0]  L_SHADOW = 3'(SHADOW);
   localparam logic [31:0] L_STEP   = 32'(ILEN_BYTES);

   logic [1:0]  r_state;
   logic [31:0] r_pc;
   logic [31:0] r_exc_pc;
   logic [31:0] r_br_cnt;

   logic        w_redirect;
   logic [31:0] w_tgt;
   logic        w_aligned;
   logic        w_pc_valid;
   logic        w_advance;
   logic        w_cnt_load;
   logic        w_cnt_dec;
   logic [2:0]  w_cnt;
   logic        w_cnt_zero;
   logic        w_shadow_done;

   // Only RUN accepts redirects; a jump outranks a simultaneous branch.
   assign w_redirect = (bus.jmp_valid | (bus.br_valid & bus.Br_en)) & (r_state == S_RUN);
   assign w_tgt      = bus.jmp_valid ? bus.jmp_target : bus.br_target;
   assign w_aligned  = (w_tgt[1:0] == 2'b00);
   assign w_pc_valid = (r_state == S_RUN) | (r_state == S_SHADOW);
   assign w_advance  = w_pc_valid & bus.imem_ready & ~bus.stall_i;

   // The window is armed both by an aligned redirect and by leaving TRAP.
   assign w_cnt_load = (w_redirect & w_aligned) | (r_state == S_TRAP);
   assign w_cnt_dec  = (r_state == S_SHADOW);

   // Leave SHADOW on the edge where the count reaches zero; the zero term
   // only guards against an out-of-range SHADOW of 0.
   assign w_shadow_done = w_cnt_zero | (w_cnt == 3'd1);

   pc_shadow_cnt u_shadow_cnt (
      .clk        (clk),
      .RSTn       (RSTn),
      .i_load     (w_cnt_load),
      .i_load_val (L_SHADOW),
      .i_dec      (w_cnt_dec),
      .o_cnt      (w_cnt),
      .o_zero     (w_cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (!RSTn) begin
         r_state  <= S_BOOT;
         r_pc     <= RESET_PC;
         r_exc_pc <= 32'h0;
         r_br_cnt <= 32'h0;
      end else begin
         case (r_state)
            S_BOOT: begin
               r_state <= S_RUN;
            end
            S_RUN: begin
               // A redirect overrides stall and memory back-pressure.
               if (w_redirect) begin
                  if (w_aligned) begin
                     r_pc    <= w_tgt;
                     r_state <= S_SHADOW;
                     if (!bus.jmp_valid) begin
                        r_br_cnt <= r_br_cnt + 32'd1;
                     end
                  end else begin
                     r_exc_pc <= w_tgt;
                     r_state  <= S_TRAP;
                  end
               end else if (w_advance) begin
                  r_pc <= r_pc + L_STEP;
               end
            end
            S_SHADOW: begin
               if (w_advance) begin
                  r_pc <= r_pc + L_STEP;
               end
               if (w_shadow_done) begin
                  r_state <= S_RUN;
               end
            end
            default: begin
               r_pc    <= TRAP_VEC;
               r_state <= S_SHADOW;
            end
         endcase
      end
   end

   assign bus.pc_o         = r_pc;
   assign bus.pc_valid     = w_pc_valid;
   assign bus.flush_o      = RSTn & w_redirect;
   assign bus.misalign_exc = (r_state == S_TRAP);
   assign bus.exc_pc       = r_exc_pc;
   assign bus.br_taken_cnt = r_br_cnt;

endmodule

// File: tb/tb_pc_redirect.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect
// Directed walk through the fetch/redirect scenarios followed by randomized
// traffic; every cycle the DUT outputs are compared against a behavioural
// model of the PC sequencer kept in this bench.
// ---------------------------------------------------------------------------
module tb_pc_redirect;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
   localparam int          SHADOW   = 2;

   logic clk;
   logic RSTn;

   pc_redirect_if bus ();

   pc_redirect #(
      .RESET_PC (RESET_PC),
      .TRAP_VEC (TRAP_VEC),
      .SHADOW   (SHADOW)
   ) dut (
      .clk  (clk),
      .RSTn (RSTn),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: what the fetch unit is doing right now
   logic [31:0] m_pc;
   logic [31:0] m_exc;
   logic [31:0] m_cnt;
   bit          m_boot;     // first cycle after reset, no fetch
   bit          m_trap;     // reporting a misaligned target this cycle
   int          m_ign;      // remaining cycles in which redirects are ignored

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc   = RESET_PC;
      m_exc  = 32'h0;
      m_cnt  = 32'h0;
      m_boot = 1'b1;
      m_trap = 1'b0;
      m_ign  = 0;
   endtask

   // One clock: drive inputs at the falling edge, compare outputs, then
   // advance the model to what the next rising edge should produce.
   task automatic step(input logic rst, input logic stall, input logic rdy,
                       input logic bv, input logic be, input logic [31:0] bt,
                       input logic jv, input logic [31:0] jt);
      bit          fetching;
      bit          want;
      logic [31:0] tgt;
      @(negedge clk);
      RSTn           = rst;
      bus.stall_i    = stall;
      bus.imem_ready = rdy;
      bus.br_valid   = bv;
      bus.Br_en      = be;
      bus.br_target  = bt;
      bus.jmp_valid  = jv;
      bus.jmp_target = jt;
      #1;
      fetching = !m_boot && !m_trap;
      want     = rst && fetching && (m_ign == 0) && (jv || (bv && be));
      chk("pc_o",         bus.pc_o,                 m_pc);
      chk("pc_valid",     32'(bus.pc_valid),        32'(fetching));
      chk("flush_o",      32'(bus.flush_o),         32'(want));
      chk("misalign_exc", 32'(bus.misalign_exc),    32'(m_trap));
      chk("exc_pc",       bus.exc_pc,               m_exc);
      chk("br_taken_cnt", bus.br_taken_cnt,         m_cnt);
      if (!rst) begin
         model_reset();
      end else if (m_boot) begin
         m_boot = 1'b0;
      end else if (m_trap) begin
         m_trap = 1'b0;
         m_pc   = TRAP_VEC;
         m_ign  = SHADOW;
      end else if (want) begin
         tgt = jv ? jt : bt;
         if (tgt % 4 == 0) begin
            m_pc  = tgt;
            m_ign = SHADOW;
            if (!jv) m_cnt = m_cnt + 1;
         end else begin
            m_trap = 1'b1;
            m_exc  = tgt;
         end
      end else begin
         if (m_ign > 0) m_ign--;
         if (rdy && !stall) m_pc = m_pc + 4;
      end
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic br(input logic [31:0] t);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, t, 1'b0, 32'h0);
   endtask

   task automatic jmp(input logic [31:0] t);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, t);
   endtask

   function automatic logic [31:0] rnd_tgt();
      logic [31:0] t;
      t = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 4) == 0) t[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) t = t | 32'hFFFF_F000;
      return t;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      RSTn           = 1'b0;
      bus.stall_i    = 1'b0;
      bus.imem_ready = 1'b1;
      bus.br_valid   = 1'b0;
      bus.Br_en      = 1'b0;
      bus.br_target  = 32'h0;
      bus.jmp_valid  = 1'b0;
      bus.jmp_target = 32'h0;
      model_reset();
      @(posedge clk);

      // Reset held with a taken branch present: no flush allowed
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
      chk("plan_reset_pc",    bus.pc_o,           32'h0);
      chk("plan_reset_flush", 32'(bus.flush_o),   32'h0);
      idle();
      chk("plan_boot_valid",  32'(bus.pc_valid),  32'h0);
      repeat (4) idle();                       // pc 0, 4, 8, 12
      br(32'h40);
      chk("plan_br_pc",       bus.pc_o,           32'h10);
      chk("plan_br_flush",    32'(bus.flush_o),   32'h1);
      br(32'h80);
      chk("plan_shadow_pc",   bus.pc_o,           32'h40);
      chk("plan_shadow_fl",   32'(bus.flush_o),   32'h0);
      br(32'h80);
      // Not-taken branch in RUN
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80, 1'b0, 32'h0);
      chk("plan_nt_pc",       bus.pc_o,           32'h48);
      chk("plan_nt_cnt",      bus.br_taken_cnt,   32'h1);
      chk("plan_nt_flush",    32'(bus.flush_o),   32'h0);
      // Jump and taken branch together: jump wins
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 32'h200);
      idle();
      chk("plan_jmp_pc",      bus.pc_o,           32'h200);
      chk("plan_jmp_cnt",     bus.br_taken_cnt,   32'h1);
      idle();
      // Misaligned branch target
      br(32'h42);
      idle();
      chk("plan_trap_exc",    32'(bus.misalign_exc), 32'h1);
      chk("plan_trap_pc",     bus.exc_pc,         32'h42);
      chk("plan_trap_valid",  32'(bus.pc_valid),  32'h0);
      idle();
      chk("plan_trapvec",     bus.pc_o,           32'h100);
      idle();
      jmp(32'h20);
      // Stall held; a taken branch still redirects
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h60, 1'b0, 32'h0);
      chk("plan_stall_pc",    bus.pc_o,           32'h20);
      chk("plan_stall_flush", 32'(bus.flush_o),   32'h1);
      // Reset during the shadow window
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      idle();
      chk("plan_rst_pc",      bus.pc_o,           32'h0);
      chk("plan_rst_valid",   32'(bus.pc_valid),  32'h0);
      // PC wrap at the top of the address space
      jmp(32'hFFFF_FFF8);
      idle();
      idle();
      idle();
      chk("plan_wrap_pc",     bus.pc_o,           32'h0);
      // Memory back-pressure
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 199) != 0),
              ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 1)),
              rnd_tgt(),
              ($urandom_range(0, 5) == 0),
              rnd_tgt());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
